// File: rtl/ifetch_stage.sv
// Instruction fetch stage: one-outstanding imem requests into a small FIFO for decode.
// Optional define IFETCH_MISALIGN_CHECK_EN turns misaligned PCs into flagged NOP entries.
module ifetch_stage #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] pc_q,
  output logic        pc_adv,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_misalign
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];

  logic          has_room;
  logic          misal;
  logic          push;
  logic          pop;
  logic [31:0]   push_pc;
  logic [31:0]   push_data;

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic          fifo_mis_q [DEPTH];
  logic          push_mis;
  assign misal = (pc_q[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  assign has_room  = (count_q < DEPTH_C);
  assign imem_addr = {pc_q[31:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    imem_req  = 1'b0;
    pc_adv    = 1'b0;
    push      = 1'b0;
    push_pc   = req_pc_q;
    push_data = imem_rdata;
`ifdef IFETCH_MISALIGN_CHECK_EN
    push_mis  = 1'b0;
`endif
    if (!RST) begin
      unique case (1'b1)
        (state_q == S_REQ): begin
          if (misal && has_room && !flush) begin
            // Misaligned PC: skip memory, hand decode a flagged NOP
            pc_adv    = 1'b1;
            push      = 1'b1;
            push_pc   = pc_q;
            push_data = NOP;
`ifdef IFETCH_MISALIGN_CHECK_EN
            push_mis  = 1'b1;
`endif
          end else begin
            imem_req = has_room && !flush;
            pc_adv   = imem_req && imem_gnt;
            if (pc_adv) begin
              req_pc_d = pc_q;
              state_d  = S_WAIT;
            end
          end
        end
        (state_q == S_WAIT): begin
          if (imem_rvalid) begin
            push    = !flush;
            state_d = S_REQ;
          end else if (flush) begin
            state_d = S_DROP;
          end
        end
        (state_q == S_DROP): begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  assign pop = inst_valid && inst_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      count_d = count_q + {{AW{1'b0}}, push}
                        - {{AW{1'b0}}, pop};
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_REQ;
      req_pc_q <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && !flush && push) begin
      fifo_data_q[wr_ptr_q] <= push_data;
      fifo_pc_q[wr_ptr_q]   <= push_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
      fifo_mis_q[wr_ptr_q]  <= push_mis;
`endif
    end
  end

  assign inst_valid = (count_q != '0);
  assign inst_data  = fifo_data_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];
`ifdef IFETCH_MISALIGN_CHECK_EN
  assign inst_misalign = fifo_mis_q[rd_ptr_q];
`else
  assign inst_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed vector table, then random traffic vs a queue model.
module tb_ifetch_stage;

  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_adv;
  logic        flush = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_misalign;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ifetch_stage #(.DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .pc_q         (pc),
    .pc_adv       (pc_adv),
    .flush        (flush),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst_ready   (inst_ready),
    .inst_data    (inst_data),
    .inst_pc      (inst_pc),
    .inst_misalign(inst_misalign)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        fl;
    logic        gnt;
    logic        rv;
    logic [31:0] rd;
    logic        rdy;
    logic        ereq;
    logic        eadv;
    logic        eval;
    logic [31:0] eipc;
    logic [31:0] eidat;
    logic        emis;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        mis;
  } ent_t;

  vec_t vt[$];

  ent_t mq[$];
  bit          m_busy = 0;
  bit          m_dead = 0;
  logic [31:0] m_pc = '0;

  task automatic add(input logic rst, input logic [31:0] p,
                     input logic fl, input logic g, input logic rv,
                     input logic [31:0] rd, input logic rdy,
                     input logic er, input logic ea, input logic ev,
                     input logic [31:0] ipc, input logic [31:0] idat,
                     input logic mis);
    vec_t v;
    v.rst = rst; v.pc = p; v.fl = fl; v.gnt = g; v.rv = rv;
    v.rd = rd; v.rdy = rdy; v.ereq = er; v.eadv = ea; v.eval = ev;
    v.eipc = ipc; v.eidat = idat; v.emis = mis;
    vt.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic [31:0] p,
                       input logic fl, input logic g, input logic rv,
                       input logic [31:0] rd, input logic rdy);
    RST = rst; pc = p; flush = fl; imem_gnt = g;
    imem_rvalid = rv; imem_rdata = rd; inst_ready = rdy;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic er,
                          input logic ea, input logic ev,
                          input logic [31:0] ipc, input logic [31:0] idat,
                          input logic mis);
    chk({tag, " req/adv/valid"},
        {29'd0, imem_req, pc_adv, inst_valid}, {29'd0, er, ea, ev});
    if (er) chk({tag, " addr"}, imem_addr, {pc[31:2], 2'b00});
    if (ev) begin
      chk({tag, " inst_pc"}, inst_pc, ipc);
      chk({tag, " inst_data"}, inst_data, idat);
      chk({tag, " misalign"}, {31'd0, inst_misalign}, {31'd0, mis});
    end
  endtask

  function automatic bit m_misal(input logic [31:0] p);
`ifdef IFETCH_MISALIGN_CHECK_EN
    return p[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit m_free();
    return !RST && !m_busy && (mq.size() < DEPTH) && !flush;
  endfunction

  function automatic bit m_req();
    return m_free() && !m_misal(pc);
  endfunction

  function automatic bit m_adv();
    return m_free() && (m_misal(pc) || imem_gnt);
  endfunction

  task automatic m_check(input int cyc);
    ent_t h;
    bit ev;
    ev = mq.size() != 0;
    h = ev ? mq[0] : '{32'd0, 32'd0, 1'b0};
    chk_outs($sformatf("rand%0d", cyc), m_req(), m_adv(), ev,
             h.pc, h.data, h.mis);
  endtask

  task automatic m_update();
    bit   popit;
    bit   do_push;
    bit   fire_mis;
    bit   fire_req;
    ent_t ne;
    if (RST) begin
      mq.delete();
      m_busy = 0;
      m_dead = 0;
      return;
    end
    popit    = (mq.size() != 0) && inst_ready;
    fire_mis = m_free() && m_misal(pc);
    fire_req = m_req() && imem_gnt;
    do_push  = 0;
    ne = '{32'd0, 32'd0, 1'b0};
    if (m_busy) begin
      if (imem_rvalid) begin
        if (!m_dead && !flush) begin
          do_push = 1;
          ne = '{m_pc, imem_rdata, 1'b0};
        end
        m_busy = 0;
        m_dead = 0;
      end else if (flush) begin
        m_dead = 1;
      end
    end else if (fire_mis) begin
      do_push = 1;
      ne = '{pc, 32'h0000_0013, 1'b1};
    end else if (fire_req) begin
      m_busy = 1;
      m_pc = pc;
    end
    if (flush) begin
      mq.delete();
    end else begin
      if (popit) void'(mq.pop_front());
      if (do_push) mq.push_back(ne);
    end
  endtask

  initial begin
    // Directed rows: each applies inputs for one cycle, checks mid-cycle
    add(0, 32'h0, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 32'h4, 0, 0, 1, 32'h00500093, 1, 0, 0, 0, 0, 0, 0);
    add(0, 32'h4, 0, 0, 0, 0, 1, 1, 0, 1, 32'h0, 32'h00500093, 0);
    add(0, 32'h4, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 32'h0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 32'h4, 0, 0, 1, 32'hA0A0_0000, 0, 0, 0, 0, 0, 0, 0);
    add(0, 32'h4, 0, 1, 0, 0, 0, 1, 1, 1, 32'h0, 32'hA0A0_0000, 0);
    add(0, 32'h8, 0, 0, 1, 32'hA4A4_0004, 0, 0, 0, 1, 32'h0, 32'hA0A0_0000, 0);
    add(0, 32'h8, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'hA0A0_0000, 0);
    add(0, 32'h8, 0, 1, 0, 0, 1, 0, 0, 1, 32'h0, 32'hA0A0_0000, 0);
    add(0, 32'h8, 0, 1, 0, 0, 1, 1, 1, 1, 32'h4, 32'hA4A4_0004, 0);
    add(0, 32'hC, 0, 0, 1, 32'hA8A8_0008, 1, 0, 0, 0, 0, 0, 0);
    add(0, 32'hC, 0, 0, 0, 0, 1, 1, 0, 1, 32'h8, 32'hA8A8_0008, 0);
    add(0, 32'hC, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 32'h10, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 32'h14, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 32'h100, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 32'h100, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 32'h100, 0, 1, 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 0);
    add(0, 32'h100, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    add(0, 32'h104, 1, 0, 1, 32'hBEEF_0001, 1, 0, 0, 0, 0, 0, 0);
    add(0, 32'h200, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 32'h200, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
`ifdef IFETCH_MISALIGN_CHECK_EN
    add(0, 32'h6, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 32'h8, 0, 0, 0, 0, 0, 1, 0, 1, 32'h6, 32'h13, 1);
    add(0, 32'h8, 1, 0, 0, 0, 0, 0, 0, 1, 32'h6, 32'h13, 1);
`else
    add(0, 32'h6, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 32'hA, 0, 0, 1, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    add(0, 32'hA, 1, 0, 0, 0, 0, 0, 0, 1, 32'h6, 32'h1234, 0);
`endif
    add(0, 32'h40, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 32'h44, 0, 0, 1, 32'hC0C0_0040, 0, 0, 0, 0, 0, 0, 0);
    add(0, 32'h44, 0, 1, 0, 0, 0, 1, 1, 1, 32'h40, 32'hC0C0_0040, 0);
    add(1, 32'h48, 0, 1, 1, 32'hC4C4_0044, 0, 0, 0, 1, 32'h40, 32'hC0C0_0040, 0);
    add(0, 32'h48, 0, 0, 1, 32'hC8C8_0048, 0, 1, 0, 0, 0, 0, 0);
    add(0, 32'h48, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Reset sequence: outputs idle while RST held
    drive(1, 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk_outs("reset", 0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;

    foreach (vt[i]) begin
      drive(vt[i].rst, vt[i].pc, vt[i].fl, vt[i].gnt,
            vt[i].rv, vt[i].rd, vt[i].rdy);
      @(negedge CLK);
      chk_outs($sformatf("vec%0d", i), vt[i].ereq, vt[i].eadv,
               vt[i].eval, vt[i].eipc, vt[i].eidat, vt[i].emis);
      @(posedge CLK); #1;
    end

    // Random traffic; first cycle resets so the model starts in step
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] p;
      p = $urandom;
      if ($urandom_range(7) != 0) p[1:0] = 2'b00;
      drive((c == 0) || ($urandom_range(63) == 0), p,
            $urandom_range(15) == 0, $urandom_range(1) == 1,
            $urandom_range(9) < 4, $urandom,
            $urandom_range(9) < 6);
      @(negedge CLK);
      m_check(c);
      @(posedge CLK);
      m_update();
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
